key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//   Input-side front end for the board push-buttons (KEY, active-low, asynchronous, bouncy).
//   Per key: 2-FF synchroniser, debounce FSM, auto-repeat timer.
//   Outputs are a clean level plus single-cycle press / release / repeat strobes.
//   These drive counter clock/load enables in place of raw KEY edges.
// PARAMETERS
//   NKEYS    2         number of independent keys
//   DEB_CYC  500000    stable cycles required to accept a press or release (>=1; 10 ms @ 50 MHz)
//   RPT_DLY  25000000  cycles from press strobe to first repeat strobe; 0 disables repeat
//   RPT_PER  5000000   cycles between successive repeat strobes (>=1)
// PORTS
//   CLK        in   1      system clock, all logic on rising edge
//   RST        in   1      synchronous, active-high reset
//   KEY        in   NKEYS  raw buttons, 0 = pressed, asynchronous to CLK
//   KEY_LVL    out  NKEYS  debounced level, 1 = pressed
//   KEY_PRESS  out  NKEYS  1-cycle strobe on accepted press
//   KEY_REL    out  NKEYS  1-cycle strobe on accepted release
//   KEY_RPT    out  NKEYS  1-cycle auto-repeat strobe while held
// BEHAVIOUR
// - Keys are fully independent: per-key sync, FSM, deb_cnt and rpt_cnt. All outputs are registered.
// - Reset:
//   - FSM = REL, counters = 0, sync FFs = released (KEY = 1), all outputs 0.
//   - Reset mid-debounce aborts the debounce; no strobe is issued.
//   - A key held through reset is treated as a new press after RST falls.
// - Synchroniser: p = ~KEY through 2 FFs. p reflects KEY after 2 rising edges.
// - FSM states and transitions:
//   - REL:   p=1 -> ARM_P, deb_cnt=0.
//   - ARM_P: p=0 -> REL (glitch rejected, no strobe).
//            deb_cnt==DEB_CYC-1 -> PRESSED, KEY_LVL<=1, KEY_PRESS pulse, rpt_cnt=0.
//            Otherwise deb_cnt++.
//   - PRESSED: p=0 -> ARM_R, deb_cnt=0. Otherwise run the repeat timer.
//   - ARM_R: p=1 -> PRESSED (release rejected; rpt_cnt holds).
//            deb_cnt==DEB_CYC-1 -> REL, KEY_LVL<=0, KEY_REL pulse.
//            Otherwise deb_cnt++.
// - Latency: KEY first sampled low at edge 1 and stable -> KEY_LVL=1 and KEY_PRESS=1 after edge DEB_CYC+3.
//   Release is symmetric.
// - KEY_PRESS and KEY_REL are high exactly one cycle, coincident with the KEY_LVL change.
// - Repeat:
//   - rpt_cnt counts every cycle in PRESSED.
//   - KEY_RPT pulses RPT_DLY cycles after the KEY_PRESS cycle, then every RPT_PER cycles.
//   - KEY_RPT is never asserted in the same cycle as KEY_PRESS.
//   - No KEY_RPT after entry to ARM_R/REL unless the release is rejected.
//   - RPT_DLY=0: KEY_RPT tied 0.
// - Counter width: $clog2 of the max of DEB_CYC, RPT_DLY and RPT_PER, plus 1. Counters never wrap
//   (they are reset on every state entry or period).
// TESTING (NKEYS=2, DEB_CYC=4, RPT_DLY=10, RPT_PER=3)
//   1. RST=1 for 3 cycles, KEY=2'b11 -> all outputs 0; stay 0 for 20 cycles after RST falls.
//   2. KEY[0]=0 held from edge 1 -> KEY_LVL[0]=1 and a 1-cycle KEY_PRESS[0] after edge 7;
//      KEY[1] outputs stay 0.
//   3. KEY[0] low 3 cycles then high -> no strobe, KEY_LVL[0]=0.
//      Then low 2 / high 1 / low stable -> KEY_PRESS[0] 7 edges after the final fall.
//   4. Hold KEY[0] 40 cycles past the press -> KEY_RPT[0] pulses at +10, +13, +16, ... after KEY_PRESS.
//   5. Release KEY[0] after test 4 -> KEY_REL[0] 7 edges later, KEY_LVL[0]=0, no further KEY_RPT.
//      A 2-cycle high glitch while held -> no KEY_REL.
//   6. RST pulsed mid ARM_P -> no KEY_PRESS.
//      Both keys held through reset -> KEY_PRESS=2'b11 in the same cycle, 7 edges after RST falls.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner
// Front end for the board push-buttons. Each raw KEY (active-low, asynchronous,
// bouncy) is synchronised, debounced and timed for auto-repeat independently.
// The module produces a clean pressed level plus single-cycle press, release and
// repeat strobes. All outputs are registered.

module key_conditioner #(
  parameter int NKEYS   = 2,
  parameter int DEB_CYC = 500000,
  parameter int RPT_DLY = 25000000,
  parameter int RPT_PER = 5000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NKEYS-1:0] KEY,
  output logic [NKEYS-1:0] KEY_LVL,
  output logic [NKEYS-1:0] KEY_PRESS,
  output logic [NKEYS-1:0] KEY_REL,
  output logic [NKEYS-1:0] KEY_RPT
);

  // One counter width serves both the debounce and the repeat timers; the
  // extra bit leaves headroom so the terminal compare is never skipped.
  localparam int MAX_DR  = (DEB_CYC > RPT_DLY) ? DEB_CYC : RPT_DLY;
  localparam int MAX_ALL = (MAX_DR > RPT_PER) ? MAX_DR : RPT_PER;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'((RPT_DLY > 0) ? (RPT_DLY - 1) : 0);
  localparam logic [CW-1:0] PER_LAST = CW'(RPT_PER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    REL     = 2'd0,
    ARM_P   = 2'd1,
    PRESSED = 2'd2,
    ARM_R   = 2'd3
  } state_t;

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    logic          r_sync1;
    logic          r_sync2;
    logic          w_p;
    state_t        r_state;
    state_t        w_stateNext;
    logic [CW-1:0] r_debCnt;
    logic [CW-1:0] w_debNext;
    logic [CW-1:0] r_rptCnt;
    logic [CW-1:0] w_rptNext;
    logic          r_rptPhase;
    logic          w_rptPhaseNext;
    logic          r_lvl;
    logic          w_lvlNext;
    logic          r_press;
    logic          w_pressNext;
    logic          r_rel;
    logic          w_relNext;
    logic          r_rpt;
    logic          w_rptNext1;

    // Two-stage synchroniser; stores the inverted key so 1 means pressed.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= ~KEY[g];
        r_sync2 <= r_sync1;
      end
    end

    assign w_p = r_sync2;

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_state    <= REL;
        r_debCnt   <= '0;
        r_rptCnt   <= '0;
        r_rptPhase <= 1'b0;
        r_lvl      <= 1'b0;
        r_press    <= 1'b0;
        r_rel      <= 1'b0;
        r_rpt      <= 1'b0;
      end else begin
        r_state    <= w_stateNext;
        r_debCnt   <= w_debNext;
        r_rptCnt   <= w_rptNext;
        r_rptPhase <= w_rptPhaseNext;
        r_lvl      <= w_lvlNext;
        r_press    <= w_pressNext;
        r_rel      <= w_relNext;
        r_rpt      <= w_rptNext1;
      end
    end

    // Next-state decision: a change must be seen DEB_CYC cycles after arming.
    always_comb begin
      w_stateNext = r_state;
      case (r_state)
        REL: begin
          if (w_p) w_stateNext = ARM_P;
        end
        ARM_P: begin
          if (!w_p)                    w_stateNext = REL;
          else if (r_debCnt == DEB_LAST) w_stateNext = PRESSED;
        end
        PRESSED: begin
          if (!w_p) w_stateNext = ARM_R;
        end
        ARM_R: begin
          if (w_p)                     w_stateNext = PRESSED;
          else if (r_debCnt == DEB_LAST) w_stateNext = REL;
        end
        default: w_stateNext = REL;
      endcase
    end

    // Counter updates and strobe generation; the repeat timer first waits
    // RPT_DLY, then switches phase to count RPT_PER between strobes.
    always_comb begin
      w_debNext      = r_debCnt;
      w_rptNext      = r_rptCnt;
      w_rptPhaseNext = r_rptPhase;
      w_lvlNext      = r_lvl;
      w_pressNext    = 1'b0;
      w_relNext      = 1'b0;
      w_rptNext1     = 1'b0;
      case (r_state)
        REL: begin
          if (w_p) w_debNext = '0;
        end
        ARM_P: begin
          if (w_p) begin
            if (r_debCnt == DEB_LAST) begin
              w_lvlNext      = 1'b1;
              w_pressNext    = 1'b1;
              w_rptNext      = '0;
              w_rptPhaseNext = 1'b0;
            end else begin
              w_debNext = r_debCnt + CNT_ONE;
            end
          end
        end
        PRESSED: begin
          if (!w_p) begin
            w_debNext = '0;
          end else if (RPT_DLY != 0) begin
            if (!r_rptPhase) begin
              if (r_rptCnt == DLY_LAST) begin
                w_rptNext1     = 1'b1;
                w_rptNext      = '0;
                w_rptPhaseNext = 1'b1;
              end else begin
                w_rptNext = r_rptCnt + CNT_ONE;
              end
            end else begin
              if (r_rptCnt == PER_LAST) begin
                w_rptNext1 = 1'b1;
                w_rptNext  = '0;
              end else begin
                w_rptNext = r_rptCnt + CNT_ONE;
              end
            end
          end
        end
        ARM_R: begin
          if (!w_p) begin
            if (r_debCnt == DEB_LAST) begin
              w_lvlNext = 1'b0;
              w_relNext = 1'b1;
            end else begin
              w_debNext = r_debCnt + CNT_ONE;
            end
          end
        end
        default: begin
          w_lvlNext = 1'b0;
        end
      endcase
    end

    assign KEY_LVL[g]   = r_lvl;
    assign KEY_PRESS[g] = r_press;
    assign KEY_REL[g]   = r_rel;
    assign KEY_RPT[g]   = r_rpt;
  end

endmodule
